axi_lite_regfile: RTL

Parametrised AXI4-Lite slave register file. It is the next-generation successor to the fixed-function demo_part2 slave.
- Provides NUM_REGS word registers, each either read/write or read-only (hardware status).
- Supports per-byte write strobes, independent address/data acceptance, SLVERR reporting, and per-register write strobes to user logic.
- Sits between the AXI-Lite interconnect and user control/status logic.

---
 rtl/axi_lite_regfile.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS word registers, each read/write or read-only
// (sourced from i_status), with byte strobes, SLVERR decode and per-register write pulses.
module axi_lite_regfile #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           i_axi_clk,
    input  logic                           i_axi_rst,
    input  logic                           i_awvalid,
    input  logic [ADDR_WIDTH-1:0]          i_awaddr,
    output logic                           o_awready,
    input  logic                           i_wvalid,
    output logic                           o_wready,
    input  logic [DATA_WIDTH-1:0]          i_wdata,
    input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
    output logic                           o_bvalid,
    input  logic                           i_bready,
    output logic [1:0]                     o_bresp,
    input  logic                           i_arvalid,
    output logic                           o_arready,
    input  logic [ADDR_WIDTH-1:0]          i_araddr,
    output logic                           o_rvalid,
    input  logic                           i_rready,
    output logic [1:0]                     o_rresp,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_status,
    output logic [NUM_REGS-1:0]            o_wr_stb
);

    localparam int STRB = DATA_WIDTH / 8;
    localparam int ALSB = $clog2(STRB);
    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;

    w_state_e                state_q, state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB-1:0]         wstrb_q, wstrb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_REGS-1:0]     wr_stb;

    logic [ADDR_WIDTH-1:0]   w_word, r_word;
    logic [IDXW-1:0]         w_idx, r_idx;
    logic                    w_in_range, r_in_range, w_ok;

    assign w_word     = awaddr_q >> ALSB;
    assign r_word     = i_araddr >> ALSB;
    assign w_idx      = w_word[IDXW-1:0];
    assign r_idx      = r_word[IDXW-1:0];
    assign w_in_range = (w_word < ADDR_WIDTH'(NUM_REGS));
    assign r_in_range = (r_word < ADDR_WIDTH'(NUM_REGS));
    assign w_ok       = w_in_range && !RO_MASK[w_idx];

    always_comb begin
        state_d   = state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        wr_stb    = '0;
        case (state_q)
            W_IDLE: begin
                o_awready = !aw_held_q;
                o_wready  = !w_held_q;
                if (i_awvalid && !aw_held_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = i_awaddr;
                end
                if (i_wvalid && !w_held_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = i_wdata;
                    wstrb_d  = i_wstrb;
                end
                if (aw_held_q && w_held_q) begin
                    state_d = W_COMMIT;
                end
            end
            W_COMMIT: begin
                // An all-zero strobe to a writable register is still a committed write.
                if (w_ok) begin
                    for (int b = 0; b < STRB; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[w_idx][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                    wr_stb[w_idx] = 1'b1;
                    bresp_d       = RESP_OKAY;
                end else begin
                    bresp_d = RESP_SLVERR;
                end
                bvalid_d  = 1'b1;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                state_d   = W_RESP;
            end
            W_RESP: begin
                if (i_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (!rvalid_q && i_arvalid) begin
            rvalid_d = 1'b1;
            if (r_in_range) begin
                rresp_d = RESP_OKAY;
                rdata_d = RO_MASK[r_idx] ? i_status[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH]
                                         : regs_q[r_idx];
            end else begin
                rresp_d = RESP_SLVERR;
                rdata_d = '0;
            end
        end else if (rvalid_q && i_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            state_q   <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int n = 0; n < NUM_REGS; n++) begin
                regs_q[n] <= RESET_VALUE;
            end
        end else begin
            state_q   <= state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    assign o_arready = !rvalid_q;
    assign o_rvalid  = rvalid_q;
    assign o_rresp   = rresp_q;
    assign o_rdata   = rdata_q;
    assign o_bvalid  = bvalid_q;
    assign o_bresp   = bresp_q;
    assign o_wr_stb  = wr_stb;

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs_out
        assign o_regs[n*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[n] ? '0 : regs_q[n];
    end

endmodule
